// File: rtl/vc_release_tracker_pkg.sv
// Shared types and helpers for the VC release tracker: per-VC state encoding
// and a constant-evaluable bit-width function.
package vc_release_tracker_pkg;

  typedef enum logic [1:0] {
    VcIdle   = 2'd0,
    VcActive = 2'd1,
    VcDrain  = 2'd2,
    VcPend   = 2'd3
  } vc_state_e;

  // Number of bits needed to represent value (minimum 1).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned bits;
    bits = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/vc_release_slot.sv
// One VC of the release tracker: packet-lifecycle FSM, occupancy counter and
// the protocol-violation terms for that VC.
module vc_release_slot
  import vc_release_tracker_pkg::*;
#(
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned LOG_DEPTH    = clogb2(BUFFER_DEPTH)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_arr,
  input  logic i_head,
  input  logic i_tail,
  input  logic i_dep,
  input  logic i_dep_tail,
  input  logic i_grant,
  output logic o_pend,
  output logic o_busy,
  output logic o_err
);

  localparam logic [LOG_DEPTH-1:0] FULL = LOG_DEPTH'(BUFFER_DEPTH);

  vc_state_e            r_state, w_state_d;
  logic [LOG_DEPTH-1:0] r_cnt, w_cnt_d;
  logic                 w_arr_ok, w_dep_ok;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_arr_ok  = 1'b0;
    w_dep_ok  = 1'b0;
    o_err     = 1'b0;

    // Classify events; a rejected event only raises the error term.
    unique case (r_state)
      VcIdle: begin
        w_arr_ok = i_arr & i_head;
        o_err    = (i_arr & ~i_head) | i_dep;
      end
      VcActive, VcDrain: begin
        w_arr_ok = i_arr & ~i_head;
        w_dep_ok = i_dep;
        o_err    = i_arr & i_head;
      end
      VcPend: begin
        w_arr_ok = i_arr & ~i_head;
        o_err    = (i_arr & i_head) | i_dep;
      end
      default: ;
    endcase

    if (w_arr_ok && !w_dep_ok) begin
      if (r_cnt == FULL) o_err = 1'b1;
      else               w_cnt_d = r_cnt + 1'b1;
    end else if (w_dep_ok && !w_arr_ok) begin
      if (r_cnt == '0) o_err = 1'b1;
      else             w_cnt_d = r_cnt - 1'b1;
    end

    // A departing tail must leave the buffer empty; resynchronise if not.
    if (w_dep_ok && i_dep_tail) begin
      if (w_cnt_d != '0) o_err = 1'b1;
      w_cnt_d = '0;
    end

    unique case (r_state)
      VcIdle: if (w_arr_ok) w_state_d = i_tail ? VcDrain : VcActive;
      VcActive: begin
        if (w_dep_ok && i_dep_tail) begin
          o_err     = 1'b1;
          w_state_d = VcPend;
        end else if (w_arr_ok && i_tail) begin
          w_state_d = VcDrain;
        end
      end
      VcDrain: if (w_dep_ok && i_dep_tail) w_state_d = VcPend;
      VcPend:  if (i_grant) w_state_d = VcIdle;
      default: ;
    endcase

    o_pend = (r_state == VcPend);
    o_busy = (r_state != VcIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= VcIdle;
      r_cnt   <= '0;
    end else if (i_enable) begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

endmodule

// File: rtl/vc_release_tracker.sv
// Router input-port VC release tracker: follows each VC's packet through its
// buffer and returns a registered one-cycle free pulse when the tail leaves.
module vc_release_tracker
  import vc_release_tracker_pkg::*;
#(
  parameter  int unsigned NVCS         = 2,
  parameter  int unsigned BUFFER_DEPTH = 8,
  localparam int unsigned LOG_NVCS     = clogb2(NVCS - 1),
  localparam int unsigned LOG_DEPTH    = clogb2(BUFFER_DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_in_valid,
  input  logic [LOG_NVCS-1:0] i_in_vc,
  input  logic                i_in_head,
  input  logic                i_in_tail,
  input  logic                i_out_valid,
  input  logic [LOG_NVCS-1:0] i_out_vc,
  input  logic                i_out_tail,
  output logic                o_free,
  output logic [LOG_NVCS-1:0] o_free_vc,
  output logic [NVCS-1:0]     o_vc_busy,
  output logic                o_error
);

  logic                r_free;
  logic [LOG_NVCS-1:0] r_free_vc;
  logic                r_error;

  logic                w_in_ok, w_out_ok, w_range_err;
  logic [NVCS-1:0]     w_pend, w_busy, w_err, w_grant;
  logic                w_any;
  logic [LOG_NVCS-1:0] w_win_idx;

  // Out-of-range indices only exist when NVCS is not a power of two.
  if (NVCS == (1 << LOG_NVCS)) begin : g_full_range
    assign w_in_ok  = 1'b1;
    assign w_out_ok = 1'b1;
  end else begin : g_part_range
    assign w_in_ok  = (32'(i_in_vc) < NVCS);
    assign w_out_ok = (32'(i_out_vc) < NVCS);
  end

  assign w_range_err = (i_in_valid & ~w_in_ok) | (i_out_valid & ~w_out_ok);

  for (genvar g = 0; g < NVCS; g++) begin : g_slot
    vc_release_slot #(
      .BUFFER_DEPTH(BUFFER_DEPTH),
      .LOG_DEPTH   (LOG_DEPTH)
    ) u_slot (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_enable   (i_enable),
      .i_arr      (i_in_valid & w_in_ok & (i_in_vc == LOG_NVCS'(g))),
      .i_head     (i_in_head),
      .i_tail     (i_in_tail),
      .i_dep      (i_out_valid & w_out_ok & (i_out_vc == LOG_NVCS'(g))),
      .i_dep_tail (i_out_tail),
      .i_grant    (w_grant[g]),
      .o_pend     (w_pend[g]),
      .o_busy     (w_busy[g]),
      .o_err      (w_err[g])
    );
  end

  // Fixed-priority release: lowest-index pending VC wins.
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = '0;
    w_grant   = '0;
    for (int unsigned v = 0; v < NVCS; v++) begin
      if (w_pend[v] && !w_any) begin
        w_any      = 1'b1;
        w_win_idx  = LOG_NVCS'(v);
        w_grant[v] = i_enable;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_free    <= 1'b0;
      r_free_vc <= '0;
      r_error   <= 1'b0;
    end else if (i_enable) begin
      r_free    <= w_any;
      r_free_vc <= w_win_idx;
      r_error   <= r_error | (|w_err) | w_range_err;
    end else begin
      r_free    <= 1'b0;
      r_free_vc <= '0;
    end
  end

  assign o_free    = r_free;
  assign o_free_vc = r_free_vc;
  assign o_vc_busy = w_busy;
  assign o_error   = r_error;

endmodule

// File: tb/tb_vc_release_tracker.sv
// Bench for vc_release_tracker: directed scenarios then random traffic, all
// checked cycle by cycle against a flag-based packet model.
module tb_vc_release_tracker;

  localparam int NV    = 2;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0, in_head = 1'b0, in_tail = 1'b0;
  logic       out_valid = 1'b0, out_tail = 1'b0;
  logic [0:0] in_vc = '0, out_vc = '0;
  logic       free;
  logic [0:0] free_vc;
  logic [1:0] vc_busy;
  logic       error;

  int checks = 0;
  int failures = 0;

  // Model: packet allocated / tail received / tail departed (awaiting release).
  bit m_alloc[NV];
  bit m_in_done[NV];
  bit m_out_done[NV];
  int m_cnt[NV];
  bit m_free;
  int m_free_vc;
  bit m_err;

  vc_release_tracker #(
    .NVCS        (NV),
    .BUFFER_DEPTH(DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (en),
    .i_in_valid  (in_valid),
    .i_in_vc     (in_vc),
    .i_in_head   (in_head),
    .i_in_tail   (in_tail),
    .i_out_valid (out_valid),
    .i_out_vc    (out_vc),
    .i_out_tail  (out_tail),
    .o_free      (free),
    .o_free_vc   (free_vc),
    .o_vc_busy   (vc_busy),
    .o_error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_alloc[v] = 0; m_in_done[v] = 0; m_out_done[v] = 0; m_cnt[v] = 0;
    end
    m_free = 0; m_free_vc = 0; m_err = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  w;
    bit  err;
    bit  a, d, a_ok, d_ok, was_idle;
    int  delta;
    if (!en) begin
      m_free = 0; m_free_vc = 0;
      return;
    end
    w = -1;
    for (int v = NV - 1; v >= 0; v--) if (m_out_done[v]) w = v;
    err = 0;
    for (int v = 0; v < NV; v++) begin
      a = in_valid && (int'(in_vc) == v);
      d = out_valid && (int'(out_vc) == v);
      was_idle = !m_alloc[v];
      if (was_idle) begin
        a_ok = a && in_head;
        d_ok = 0;
        if ((a && !in_head) || d) err = 1;
      end else begin
        if (a && in_head) err = 1;
        a_ok = a && !in_head;
        if (m_out_done[v]) begin
          if (d) err = 1;
          d_ok = 0;
        end else begin
          d_ok = d;
        end
      end
      delta = int'(a_ok) - int'(d_ok);
      if (delta == 1) begin
        if (m_cnt[v] == DEPTH) err = 1; else m_cnt[v]++;
      end else if (delta == -1) begin
        if (m_cnt[v] == 0) err = 1; else m_cnt[v]--;
      end
      if (d_ok && out_tail) begin
        if (m_cnt[v] != 0) err = 1;
        if (!m_in_done[v]) err = 1;
        m_cnt[v] = 0;
        m_out_done[v] = 1;
      end
      if (a_ok) begin
        if (was_idle) begin
          m_alloc[v] = 1;
          m_in_done[v] = in_tail;
        end else if (in_tail) begin
          m_in_done[v] = 1;
        end
      end
      if (v == w) begin
        m_alloc[v] = 0; m_in_done[v] = 0; m_out_done[v] = 0;
      end
    end
    if (err) m_err = 1;
    m_free = (w >= 0);
    m_free_vc = (w >= 0) ? w : 0;
  endtask

  task automatic drive(input bit e, input bit iv, input int ivc, input bit h, input bit t,
                       input bit ov, input int ovc, input bit ot);
    en = e; in_valid = iv; in_vc = ivc[0:0]; in_head = h; in_tail = t;
    out_valid = ov; out_vc = ovc[0:0]; out_tail = ot;
  endtask

  task automatic idle_in();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, "_free"}, 32'(free), 32'(m_free));
    check({tag, "_free_vc"}, 32'(free_vc), 32'(m_free_vc));
    check({tag, "_busy"}, 32'(vc_busy), 32'({m_alloc[1], m_alloc[0]}));
    check({tag, "_error"}, 32'(error), 32'(m_err));
  endtask

  // Asynchronous assertion mid-cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_free"}, 32'(free), 32'd0);
    check({tag, "_rst_free_vc"}, 32'(free_vc), 32'd0);
    check({tag, "_rst_busy"}, 32'(vc_busy), 32'd0);
    check({tag, "_rst_error"}, 32'(error), 32'd0);
    model_reset();
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // T1: single-flit packet on VC1
    do_reset("t1");
    drive(1, 1, 1, 1, 1, 0, 0, 0); tick("t1_in");
    check("t1_busy_after_in", 32'(vc_busy), 32'b10);
    drive(1, 0, 0, 0, 0, 1, 1, 1); tick("t1_out");
    check("t1_no_early_free", 32'(free), 32'd0);
    idle_in(); tick("t1_rel");
    check("t1_free", 32'(free), 32'd1);
    check("t1_free_vc", 32'(free_vc), 32'd1);
    check("t1_busy_clear", 32'(vc_busy), 32'd0);
    idle_in(); tick("t1_after");
    check("t1_one_cycle", 32'(free), 32'd0);

    // T2: 4-flit packet on VC0, interleaved departures, peak count 3
    do_reset("t2");
    drive(1, 1, 0, 1, 0, 0, 0, 0); tick("t2_c1");
    drive(1, 1, 0, 0, 0, 0, 0, 0); tick("t2_c2");
    drive(1, 1, 0, 0, 0, 0, 0, 0); tick("t2_c3");
    drive(1, 1, 0, 0, 1, 1, 0, 0); tick("t2_c4");
    drive(1, 0, 0, 0, 0, 1, 0, 0); tick("t2_c5");
    drive(1, 0, 0, 0, 0, 1, 0, 0); tick("t2_c6");
    drive(1, 0, 0, 0, 0, 1, 0, 1); tick("t2_c7");
    check("t2_busy_pend", 32'(vc_busy), 32'b01);
    idle_in(); tick("t2_rel");
    check("t2_free", 32'(free), 32'd1);
    check("t2_free_vc", 32'(free_vc), 32'd0);
    check("t2_no_error", 32'(error), 32'd0);
    idle_in(); tick("t2_after");

    // T3: back-to-back releases, lower VC first, then quiet
    do_reset("t3");
    drive(1, 1, 0, 1, 1, 0, 0, 0); tick("t3_in0");
    drive(1, 1, 1, 1, 1, 0, 0, 0); tick("t3_in1");
    drive(1, 0, 0, 0, 0, 1, 0, 1); tick("t3_out0");
    drive(1, 0, 0, 0, 0, 1, 1, 1); tick("t3_out1");
    check("t3_first_vc", 32'(free_vc), 32'd0);
    idle_in(); tick("t3_second");
    check("t3_second_free", 32'(free), 32'd1);
    check("t3_second_vc", 32'(free_vc), 32'd1);
    idle_in(); tick("t3_quiet");
    check("t3_no_third", 32'(free), 32'd0);

    // T5: VC1 pending while disabled, head arrives on PEND VC
    do_reset("t5");
    drive(1, 1, 1, 1, 1, 0, 0, 0); tick("t5_in");
    drive(1, 0, 0, 0, 0, 1, 1, 1); tick("t5_out");
    drive(0, 1, 1, 1, 0, 0, 0, 0); tick("t5_dis0");
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("t5_dis1");
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("t5_dis2");
    check("t5_held_busy", 32'(vc_busy), 32'b10);
    check("t5_no_free_dis", 32'(free), 32'd0);
    drive(1, 1, 1, 1, 0, 0, 0, 0); tick("t5_en");
    check("t5_error", 32'(error), 32'd1);
    check("t5_free_vc", 32'(free_vc), 32'd1);
    idle_in(); tick("t5_after");

    // T4: overflow on the 9th arrival, error sticky
    do_reset("t4");
    drive(1, 1, 0, 1, 0, 0, 0, 0); tick("t4_head");
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0); tick("t4_fill");
    end
    check("t4_full_no_err", 32'(error), 32'd0);
    drive(1, 1, 0, 0, 0, 0, 0, 0); tick("t4_ninth");
    check("t4_overflow", 32'(error), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle_in(); tick("t4_sticky");
    end
    check("t4_still_err", 32'(error), 32'd1);

    // T6: reset mid-packet
    do_reset("t6a");
    drive(1, 1, 0, 1, 0, 0, 0, 0); tick("t6_head");
    drive(1, 1, 0, 0, 0, 0, 0, 0); tick("t6_body");
    check("t6_busy", 32'(vc_busy), 32'b01);
    do_reset("t6b");
    for (int i = 0; i < 4; i++) begin
      idle_in(); tick("t6_post");
    end
    check("t6_no_free", 32'(free), 32'd0);

    // Random traffic, mostly legal, periodically reset to clear sticky error
    for (int n = 0; n < 3000; n++) begin
      int  ivc, ovc;
      bit  e, iv, h, t, ov, ot;
      if (n % 250 == 0) do_reset("rnd");
      e   = ($urandom_range(0, 9) != 0);
      iv  = ($urandom_range(0, 1) != 0);
      ivc = $urandom_range(0, NV - 1);
      if (!m_alloc[ivc]) h = ($urandom_range(0, 9) != 0);
      else               h = ($urandom_range(0, 19) == 0);
      t   = ($urandom_range(0, 2) == 0);
      ov  = ($urandom_range(0, 1) != 0);
      ovc = $urandom_range(0, NV - 1);
      if (m_in_done[ovc] && m_cnt[ovc] == 1) ot = ($urandom_range(0, 9) != 0);
      else                                   ot = ($urandom_range(0, 19) == 0);
      drive(e, iv, ivc, h, t, ov, ovc, ot);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
